// File: rtl/gpu_pkg.sv
// Shared GPU vertex-path constants, FSM state type and the transfer-length helper.
package gpu_pkg;

    localparam int M                = 11;
    localparam int N                = 7;
    localparam int VERTEX_MEM_DEPTH = 16384;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    // Transfer length: whole groups of 4 words, never more than the RAM holds.
    function automatic logic [31:0] clamp_len(input logic [31:0] cnt, input logic [31:0] depth);
        logic [31:0] masked;
        masked = cnt & ~32'd3;
        return (masked > depth) ? depth : masked;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; head entry is always on rdata.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        // A pop frees the slot in the same cycle, so full+pop+push is legal.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/transformed_vertex_reader.sv
// Streams len words out of the transformed-vertex RAM over a valid/ready master port,
// issuing reads only when the output FIFO has room for them.
module transformed_vertex_reader
    import gpu_pkg::*;
#(
    parameter int DATA_W     = M + N,
    parameter int DEPTH      = VERTEX_MEM_DEPTH,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       vertex_count,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   issue_left_q, issue_left_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic          inflight_last_q, inflight_last_d;

    logic [31:0]   len;
    logic          credit_ok, issue, pop;
    logic [DATA_W:0] fifo_rdata;
    logic          fifo_valid;
    logic [CW-1:0] fifo_count;

    assign len = clamp_len(vertex_count, 32'(DEPTH));
    assign pop = fifo_valid && m_tready;

    always_comb begin
        state_d      = state_q;
        issue_left_d = issue_left_q;
        addr_d       = addr_q;
        issue        = 1'b0;
        // Every outstanding read must already own a FIFO slot when it lands.
        credit_ok    = (32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = '0;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        issue_left_d = len;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue        = 1'b1;
                    issue_left_d = issue_left_q - 32'd1;
                    // Address parks on len-1 so it never wraps past the transfer.
                    if (issue_left_q == 32'd1) state_d = DRAIN;
                    else                       addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (pop && fifo_rdata[DATA_W]) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inflight_d      = issue;
        inflight_last_d = issue && (issue_left_q == 32'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            issue_left_q    <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            issue_left_q    <= issue_left_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .wdata ({inflight_last_q, mem_rd_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign mem_rd_addr = addr_q;
    assign m_tvalid    = fifo_valid;
    // Empty FIFO entries are uninitialised; show zeros instead of stale storage.
    assign m_tdata     = fifo_valid ? fifo_rdata[DATA_W-1:0] : '0;
    assign m_tlast     = fifo_valid && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_transformed_vertex_reader.sv
// Directed + randomized bench: behavioural RAM, per-transfer reference of expected beats.
module tb_transformed_vertex_reader;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 16384;
    localparam int AW     = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       vertex_count = '0;
    logic              busy, done, m_tvalid, m_tlast;
    logic              m_tready = 1'b0;
    logic [AW-1:0]     mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data, m_tdata;

    logic [DATA_W-1:0] ram [DEPTH];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_rd_data <= ram[mem_rd_addr];

    transformed_vertex_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vertex_count (vertex_count),
        .busy         (busy),
        .done         (done),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_len(input longint cnt);
        longint m;
        m = cnt - (cnt % 4);
        return (m > DEPTH) ? DEPTH : int'(m);
    endfunction

    // One transfer; samples at negedges, cycle 1 = first negedge after start is sampled.
    task automatic do_transfer(input int count, input int rdy_pct, input bit extra_start);
        int len, idx, cyc, first, done_cnt, done_cyc, last_cyc, budget, max_addr;
        bit hold, hold_last;
        logic [DATA_W-1:0] hold_data;
        len = model_len(count);
        budget = len * 8 + 40;
        idx = 0; first = -1; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        hold = 1'b0; hold_last = 1'b0; hold_data = '0; max_addr = 0;
        @(negedge clk);
        start = 1'b1; vertex_count = count;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (cyc < budget) begin
            m_tready = ($urandom_range(99) < rdy_pct);
            if (extra_start) begin
                start = (cyc == 4);
                if (cyc == 4) vertex_count = 64;
            end
            if (m_tvalid && first < 0) first = cyc;
            if (busy && int'(mem_rd_addr) > max_addr) max_addr = int'(mem_rd_addr);
            if (hold) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, hold_data);
                check("hold_last", m_tlast, hold_last);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (m_tvalid && m_tready) begin
                check("beat_data", m_tdata, (idx < len) ? ram[idx] : 'x);
                check("beat_last", m_tlast, (idx == len - 1));
                if (m_tlast) last_cyc = cyc;
                idx++;
                hold = 1'b0;
            end else begin
                hold = m_tvalid; hold_data = m_tdata; hold_last = m_tlast;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("beat_count", idx, len);
        check("done_count", done_cnt, 1);
        check("done_time", done_cyc, (len == 0) ? 1 : last_cyc + 1);
        check("busy_end", busy, 0);
        if (len > 0) begin
            check("first_valid", first, 3);
            check("last_addr", max_addr, len - 1);
        end else begin
            check("no_valid", first, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i + 100);

        // Reset held 3 cycles
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_tvalid, 0);
        check("rst_last", m_tlast, 0);
        check("rst_data", m_tdata, 0);
        check("rst_addr", mem_rd_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Basic, rounding, zero
        do_transfer(8, 100, 1'b0);
        do_transfer(7, 100, 1'b0);
        do_transfer(3, 100, 1'b0);
        do_transfer(0, 100, 1'b0);

        // Backpressure with random RAM contents
        for (int i = 0; i < 64; i++) ram[i] = DATA_W'($urandom);
        do_transfer(16, 50, 1'b0);
        for (int k = 0; k < 6; k++) do_transfer(int'($urandom_range(40)), int'($urandom_range(20, 90)), 1'b0);

        // Start while busy must be ignored
        do_transfer(8, 70, 1'b1);

        // Abort by reset after 5 beats
        begin
            int beats, cyc, dones, vals;
            for (int i = 0; i < 64; i++) ram[i] = DATA_W'(i + 100);
            @(negedge clk);
            start = 1'b1; vertex_count = 16; m_tready = 1'b1;
            @(negedge clk);
            start = 1'b0; beats = 0; cyc = 0;
            while (beats < 5 && cyc < 50) begin
                if (m_tvalid && m_tready) beats++;
                if (beats < 5) begin @(negedge clk); cyc++; end
            end
            check("abort_beats", beats, 5);
            reset = 1'b1;
            @(negedge clk);
            check("abort_valid", m_tvalid, 0);
            check("abort_busy", busy, 0);
            reset = 1'b0;
            dones = 0; vals = 0;
            repeat (20) begin
                @(negedge clk);
                if (done) dones++;
                if (m_tvalid) vals++;
            end
            check("abort_no_done", dones, 0);
            check("abort_no_beats", vals, 0);
        end

        // Clamp to RAM depth
        do_transfer(20000, 100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
